// File: rtl/opl3_pkg.sv
// rtl/opl3_pkg.sv - shared OPL3 types: host port map and register-write beat
package opl3_pkg;

  localparam int HOST_ADDR_WIDTH = 2;

  typedef enum logic [1:0] {
    HOST_ADDR0,
    HOST_DATA0,
    HOST_ADDR1,
    HOST_DATA1
  } host_port_t;

  typedef struct packed {
    logic       valid;
    logic       bank_num;
    logic [7:0] address;
    logic [7:0] data;
  } opl3_reg_wr_t;

  // Queued write: everything in a beat except valid.
  typedef struct packed {
    logic       bank_num;
    logic [7:0] address;
    logic [7:0] data;
  } reg_entry_t;

  localparam int REG_ENTRY_WIDTH = $bits(reg_entry_t);

endpackage

// File: rtl/opl3_sync_fifo.sv
// rtl/opl3_sync_fifo.sv - single-clock FIFO with count, synchronous reset
module opl3_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is still legal when the same edge frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/opl3_host_reg_writer.sv
// rtl/opl3_host_reg_writer.sv - OPL3 4-port host bus to paced register-write beats
module opl3_host_reg_writer
  import opl3_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_GAP     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [HOST_ADDR_WIDTH-1:0] host_addr,
  input  logic [7:0]                 host_din,
  input  logic                       host_wr,
  input  logic                       irq,
  input  logic                       ft1,
  input  logic                       ft2,
  output logic [7:0]                 host_dout,
  output logic                       host_busy,
  output logic                       overflow,
  output opl3_reg_wr_t               opl3_reg_wr
);

  localparam int GW = $clog2(WR_GAP + 1);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(WR_GAP - 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  host_port_t   port;
  logic         is_addr, is_data, push, pop;
  logic         fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  reg_entry_t   push_entry, pop_entry;

  logic [7:0]   addr_q, addr_d;
  logic         bank_q, bank_d;
  logic         overflow_q, overflow_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]   dout_q, dout_d;
  opl3_reg_wr_t reg_wr_q, reg_wr_d;

  assign port    = host_port_t'(host_addr);
  assign is_addr = host_wr && (port == HOST_ADDR0 || port == HOST_ADDR1);
  assign is_data = host_wr && (port == HOST_DATA0 || port == HOST_DATA1);

  assign pop  = !fifo_empty && (gap_q == '0);
  assign push = is_data && (!fifo_full || pop);

  // Bank travels with the entry from the last address-port write.
  assign push_entry = '{bank_num: bank_q, address: addr_q, data: host_din};

  opl3_sync_fifo #(
    .WIDTH (REG_ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (pop_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    addr_d         = addr_q;
    bank_d         = bank_q;
    overflow_d     = overflow_q | (is_data && !push);
    gap_d          = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
    dout_d         = {irq, ft1, ft2, 5'b0};
    reg_wr_d       = reg_wr_q;
    reg_wr_d.valid = 1'b0;
    if (is_addr) begin
      addr_d = host_din;
      bank_d = (port == HOST_ADDR1);
    end
    if (pop) begin
      gap_d    = GAP_RELOAD;
      reg_wr_d = '{valid: 1'b1, bank_num: pop_entry.bank_num,
                   address: pop_entry.address, data: pop_entry.data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      bank_q     <= 1'b0;
      overflow_q <= 1'b0;
      gap_q      <= '0;
      dout_q     <= '0;
      reg_wr_q   <= '0;
    end else begin
      addr_q     <= addr_d;
      bank_q     <= bank_d;
      overflow_q <= overflow_d;
      gap_q      <= gap_d;
      dout_q     <= dout_d;
      reg_wr_q   <= reg_wr_d;
    end
  end

  assign host_busy   = (fifo_count == DEPTH_C);
  assign host_dout   = dout_q;
  assign overflow    = overflow_q;
  assign opl3_reg_wr = reg_wr_q;

endmodule
